// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle RV32I sequencer.
// States, opcodes and ALU encodings live here.
package ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC_I,
        EXEC_B,
        MEM_RD,
        WB_ALU,
        WB_MEM,
        TRAP
    } state_t;

    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_CMP = 3'b111;

    // addi and lw share the I-type immediate path
    function automatic logic is_imm_op(input logic [6:0] op);
        return (op == OP_ITYPE) || (op == OP_LOAD);
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// Moore sequencer stepping each instruction through fetch..writeback.
// Drives datapath enables/muxes and counts retired instructions.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             imem_ready,
    input  logic [6:0]       instr_opcode,
    input  logic             EQ,
    input  logic             dmem_ready,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCsrc,
    output logic             RegWrite,
    output logic             ResultSrc,
    output logic [2:0]       ALUctrl,
    output logic             ALUsrc,
    output logic             ImmSrc,
    output logic             MemRead,
    output logic             trap,
    output logic [CNT_W-1:0] retired
);

    state_t state;
    state_t next;
    logic   retire;

    // State register; reset abandons any instruction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= next;
        end
    end

    // Next-state and Moore outputs (EQ only matters in EXEC_B)
    always_comb begin
        next      = state;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        PCsrc     = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = 1'b0;
        ALUctrl   = ALU_ADD;
        ALUsrc    = 1'b0;
        ImmSrc    = 1'b0;
        MemRead   = 1'b0;
        trap      = 1'b0;
        retire    = 1'b0;
        unique case (state)
            FETCH: begin
                if (imem_ready) begin
                    IRWrite = 1'b1;
                    next    = DECODE;
                end
            end
            DECODE: begin
                ImmSrc = is_imm_op(instr_opcode);
                if (is_imm_op(instr_opcode)) begin
                    next = EXEC_I;
                end else if (instr_opcode == OP_BRANCH) begin
                    next = EXEC_B;
                end else begin
                    next = TRAP;
                end
            end
            EXEC_I: begin
                ALUctrl = ALU_ADD;
                ALUsrc  = 1'b1;
                ImmSrc  = 1'b1;
                if (instr_opcode == OP_LOAD) begin
                    next = MEM_RD;
                end else begin
                    next = WB_ALU;
                end
            end
            EXEC_B: begin
                ALUctrl = ALU_CMP;
                PCWrite = 1'b1;
                PCsrc   = ~EQ;
                retire  = 1'b1;
                next    = FETCH;
            end
            MEM_RD: begin
                MemRead = 1'b1;
                ALUctrl = ALU_ADD;
                ALUsrc  = 1'b1;
                ImmSrc  = 1'b1;
                if (dmem_ready) begin
                    next = WB_MEM;
                end
            end
            WB_ALU: begin
                RegWrite = 1'b1;
                ALUctrl  = ALU_ADD;
                ALUsrc   = 1'b1;
                PCWrite  = 1'b1;
                retire   = 1'b1;
                next     = FETCH;
            end
            WB_MEM: begin
                RegWrite  = 1'b1;
                ResultSrc = 1'b1;
                PCWrite   = 1'b1;
                retire    = 1'b1;
                next      = FETCH;
            end
            TRAP: begin
                trap = 1'b1;
            end
            default: begin
                next = FETCH;
            end
        endcase
    end

    // Retired-instruction counter, wraps naturally at CNT_W bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired <= '0;
        end else if (retire) begin
            retired <= retired + 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control with hand-computed vectors.
// Output bundle order: IRW PCW PCs RegW Res ALU[2:0] ALUs Imm MemRd trap.
module tb_multicycle_control;

    logic       clk;
    logic       rst_n;
    logic       imem_ready;
    logic [6:0] instr_opcode;
    logic       EQ;
    logic       dmem_ready;
    logic       IRWrite;
    logic       PCWrite;
    logic       PCsrc;
    logic       RegWrite;
    logic       ResultSrc;
    logic [2:0] ALUctrl;
    logic       ALUsrc;
    logic       ImmSrc;
    logic       MemRead;
    logic       trap;
    logic [3:0] retired;

    int n_cmp;
    int n_err;

    localparam logic [6:0] ADDI = 7'b0010011;
    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] BNE  = 7'b1100011;
    localparam logic [6:0] ILL  = 7'b0110011;

    localparam logic [11:0] O_NONE  = 12'h000;
    localparam logic [11:0] O_FETCH = 12'h800;
    localparam logic [11:0] O_DEC_I = 12'h004;
    localparam logic [11:0] O_EXI   = 12'h00C;
    localparam logic [11:0] O_EXB_T = 12'h670;
    localparam logic [11:0] O_EXB_N = 12'h470;
    localparam logic [11:0] O_MEMRD = 12'h00E;
    localparam logic [11:0] O_WBALU = 12'h508;
    localparam logic [11:0] O_WBMEM = 12'h580;
    localparam logic [11:0] O_TRAP  = 12'h001;

    multicycle_control #(.CNT_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_ready   (imem_ready),
        .instr_opcode (instr_opcode),
        .EQ           (EQ),
        .dmem_ready   (dmem_ready),
        .IRWrite      (IRWrite),
        .PCWrite      (PCWrite),
        .PCsrc        (PCsrc),
        .RegWrite     (RegWrite),
        .ResultSrc    (ResultSrc),
        .ALUctrl      (ALUctrl),
        .ALUsrc       (ALUsrc),
        .ImmSrc       (ImmSrc),
        .MemRead      (MemRead),
        .trap         (trap),
        .retired      (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] outs();
        return {IRWrite, PCWrite, PCsrc, RegWrite, ResultSrc,
                ALUctrl, ALUsrc, ImmSrc, MemRead, trap};
    endfunction

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge: drive, check mid-cycle, advance
    task automatic step(input logic im, input logic dm,
                        input logic eq, input logic [11:0] exp,
                        input string tag);
        imem_ready = im;
        dmem_ready = dm;
        EQ         = eq;
        @(negedge clk);
        chk(tag, {20'h0, outs()}, {20'h0, exp});
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        rst_n        = 1'b0;
        imem_ready   = 1'b0;
        dmem_ready   = 1'b0;
        EQ           = 1'b0;
        instr_opcode = 7'h00;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_outs", {20'h0, outs()}, 32'h0);
        chk("rst_ret", {28'h0, retired}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // addi, no wait states
        instr_opcode = ADDI;
        step(1, 0, 0, O_FETCH, "addi_c1");
        step(0, 0, 0, O_DEC_I, "addi_c2");
        step(0, 0, 0, O_EXI,   "addi_c3");
        step(0, 0, 0, O_WBALU, "addi_c4");
        chk("addi_ret", {28'h0, retired}, 32'd1);

        // bne taken then not taken
        instr_opcode = BNE;
        step(1, 0, 0, O_FETCH, "bne0_c1");
        step(0, 0, 0, O_NONE,  "bne0_c2");
        step(0, 0, 0, O_EXB_T, "bne0_c3");
        chk("bne0_ret", {28'h0, retired}, 32'd2);
        step(1, 0, 1, O_FETCH, "bne1_c1");
        step(0, 0, 1, O_NONE,  "bne1_c2");
        step(0, 0, 1, O_EXB_N, "bne1_c3");
        chk("bne1_ret", {28'h0, retired}, 32'd3);

        // lw with three data wait states
        instr_opcode = LW;
        step(1, 0, 0, O_FETCH, "lw_c1");
        step(0, 0, 0, O_DEC_I, "lw_c2");
        step(0, 0, 0, O_EXI,   "lw_c3");
        step(0, 0, 0, O_MEMRD, "lw_c4");
        step(0, 0, 0, O_MEMRD, "lw_c5");
        step(0, 0, 0, O_MEMRD, "lw_c6");
        chk("lw_wait_ret", {28'h0, retired}, 32'd3);
        step(0, 1, 0, O_MEMRD, "lw_c7");
        step(0, 0, 0, O_WBMEM, "lw_c8");
        chk("lw_ret", {28'h0, retired}, 32'd4);

        // two fetch wait states; stray readies ignored later
        instr_opcode = ADDI;
        step(0, 0, 0, O_NONE,  "fw_c1");
        step(0, 0, 0, O_NONE,  "fw_c2");
        step(1, 0, 0, O_FETCH, "fw_c3");
        step(1, 1, 0, O_DEC_I, "fw_c4");
        step(1, 1, 0, O_EXI,   "fw_c5");
        step(1, 1, 0, O_WBALU, "fw_c6");
        chk("fw_ret", {28'h0, retired}, 32'd5);

        // counter wrap: 10 bne to reach 15, one more to 0
        instr_opcode = BNE;
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 0, O_FETCH, "wrap_f");
            step(0, 0, 0, O_NONE,  "wrap_d");
            step(0, 0, 0, O_EXB_T, "wrap_x");
        end
        chk("wrap_15", {28'h0, retired}, 32'd15);
        step(1, 0, 1, O_FETCH, "wrap_f");
        step(0, 0, 1, O_NONE,  "wrap_d");
        step(0, 0, 1, O_EXB_N, "wrap_x");
        chk("wrap_0", {28'h0, retired}, 32'd0);

        // reset asserted while lw waits in MEM_RD
        instr_opcode = LW;
        step(1, 0, 0, O_FETCH, "rmem_c1");
        step(0, 0, 0, O_DEC_I, "rmem_c2");
        step(0, 0, 0, O_EXI,   "rmem_c3");
        step(0, 0, 0, O_MEMRD, "rmem_c4");
        dmem_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rmem_outs", {20'h0, outs()}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        dmem_ready = 1'b0;
        step(0, 0, 0, O_NONE, "rmem_idle1");
        step(0, 0, 0, O_NONE, "rmem_idle2");
        chk("rmem_ret", {28'h0, retired}, 32'd0);

        // illegal opcode traps until reset
        instr_opcode = ILL;
        step(1, 0, 0, O_FETCH, "trap_c1");
        step(0, 0, 0, O_NONE,  "trap_c2");
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, O_TRAP, "trap_hold");
        end
        chk("trap_ret", {28'h0, retired}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("trap_clr", {31'h0, trap}, 32'h0);
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        @(negedge clk);
        chk("trap_rst_outs", {20'h0, outs()}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
